fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation (pipelined) RISC-V core. It replaces the bare PC register plus +4 adder with a PC generator that issues in-order requests to a variable-latency instruction memory and buffers returned words with their PCs in a DEPTH-entry queue toward decode. Redirects from the branch/jump logic flush the queue and discard in-flight responses.

---
 rtl/fetch_if.sv | 38 +++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch unit's memory, decode and redirect signals.
//   master : fetch_unit side (drives requests, queue head and busy)
//   slave  : environment side (memory, decode and branch logic)
//   req_*   : request channel toward instruction memory
//   resp_*  : in-order response channel from instruction memory
//   out_*   : queue head toward decode
//   redirect/redirect_pc : one-cycle restart pulse and target
//   busy    : requests outstanding or instructions buffered
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// edge where valid and ready are both 1. The response channel has no ready;
// resp_valid transfers one word on every edge where it is high.
interface fetch_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_instr, busy,
    input  req_ready, resp_valid, resp_data, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_instr, busy,
    output req_ready, resp_valid, resp_data, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Generates sequential fetch PCs,
// issues in-order requests to a variable-latency memory, tags each request
// with its PC, and buffers returned words in a DEPTH-entry queue toward decode.
// A redirect flushes the queue and marks every unanswered request as stale.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : fetch_if.master (request, response, decode and redirect signals)
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] pc_q, pc_d;
  cnt_t            count_q, count_d;
  cnt_t            inflight_q, inflight_d;
  cnt_t            drop_q, drop_d;
  ptr_t            head_q, head_d;
  ptr_t            tail_q, tail_d;
  ptr_t            tag_wr_q, tag_wr_d;
  ptr_t            tag_rd_q, tag_rd_d;
  logic [XLEN-1:0] q_pc_q    [DEPTH];
  logic [XLEN-1:0] q_pc_d    [DEPTH];
  logic [XLEN-1:0] q_instr_q [DEPTH];
  logic [XLEN-1:0] q_instr_d [DEPTH];
  logic [XLEN-1:0] tag_q     [DEPTH];
  logic [XLEN-1:0] tag_d     [DEPTH];

  logic        accept;
  logic        resp;
  logic        deq;
  logic        enq;
  logic [CW:0] credit_used;

  // Buffered plus outstanding words never exceed DEPTH, so every response
  // is guaranteed a queue slot.
  assign credit_used   = {1'b0, count_q} + {1'b0, inflight_q};
  assign bus.req_valid = !reset && (credit_used < DEPTH_W);
  assign bus.req_addr  = pc_q;
  assign accept        = bus.req_valid && bus.req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp          = bus.resp_valid && (inflight_q != '0);
  assign bus.out_valid = (count_q != '0);
  assign deq           = bus.out_valid && bus.out_ready;
  assign enq           = resp && (drop_q == '0) && !bus.redirect;
  assign bus.out_pc    = bus.out_valid ? q_pc_q[head_q]    : '0;
  assign bus.out_instr = bus.out_valid ? q_instr_q[head_q] : '0;
  assign bus.busy      = (inflight_q != '0) || (count_q != '0);

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    q_pc_d     = q_pc_q;
    q_instr_d  = q_instr_q;
    tag_d      = tag_q;

    if (accept) begin
      tag_d[tag_wr_q] = pc_q;
      tag_wr_d        = tag_wr_q + ptr_t'(1);
      pc_d            = pc_q + XLEN'(4);
    end

    if (resp) begin
      tag_rd_d = tag_rd_q + ptr_t'(1);
      if (drop_q != '0) drop_d = drop_q - cnt_t'(1);
    end

    if (enq) begin
      q_pc_d[tail_q]    = tag_q[tag_rd_q];
      q_instr_d[tail_q] = bus.resp_data;
      tail_d            = tail_q + ptr_t'(1);
    end

    if (deq) head_d = head_q + ptr_t'(1);

    inflight_d = inflight_q + cnt_t'(accept) - cnt_t'(resp);
    count_d    = count_q + cnt_t'(enq) - cnt_t'(deq);

    // Everything still unanswered after this cycle, including a request
    // accepted in the redirect cycle itself, belongs to the old path.
    if (bus.redirect) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      pc_d    = bus.redirect_pc & ~XLEN'(3);
      drop_d  = inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
    end
  end

  // Storage is qualified by the counters and pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    q_pc_q    <= q_pc_d;
    q_instr_q <= q_instr_d;
    tag_q     <= tag_d;
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fetch_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- counters and knobs ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  bit check_en = 1'b0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100, ordy_pct = 100, rdr_pct = 0;

  // ---------------- memory model ----------------
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } pend_t;
  pend_t pend[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_tags[$];
  logic [31:0] m_pc = RESET_PC;
  int          m_drop = 0;
  logic        m_rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_outputs();
    logic ov;
    m_rv = !reset && ((m_q.size() + m_tags.size()) < DEPTH);
    ov   = (m_q.size() > 0);
    check("req_valid", 32'(bus.req_valid), 32'(m_rv));
    check("req_addr",  bus.req_addr, m_pc);
    check("out_valid", 32'(bus.out_valid), 32'(ov));
    check("out_pc",    bus.out_pc,    ov ? m_q[0].pc    : 32'h0);
    check("out_instr", bus.out_instr, ov ? m_q[0].instr : 32'h0);
    check("busy",      32'(bus.busy), 32'(ov || (m_tags.size() > 0)));
  endtask

  task automatic model_step(input logic rst, input logic acc, input logic rsp,
                            input logic ordy, input logic rdr, input logic [31:0] rpc);
    logic [31:0] t;
    if (rst) begin
      m_q.delete();
      m_tags.delete();
      m_drop = 0;
      m_pc   = RESET_PC;
      return;
    end
    if ((m_q.size() > 0) && ordy) void'(m_q.pop_front());
    if (rsp && (m_tags.size() > 0)) begin
      t = m_tags.pop_front();
      if (!rdr) begin
        if (m_drop > 0) m_drop--;
        else m_q.push_back({t, mem_word(t)});
      end
    end
    if (acc) begin
      m_tags.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (rdr) begin
      m_q.delete();
      m_pc   = rpc & ~32'h3;
      m_drop = m_tags.size();
    end
  endtask

  // ---------------- one clock cycle: drive, compare, advance ----------------
  task automatic run_cycle(input logic rst, input logic force_rdr, input logic [31:0] rpc);
    logic        rdr;
    logic [31:0] tgt;
    logic        s_rv;
    logic [31:0] s_ra;
    @(negedge clk);
    reset = rst;
    bus.req_ready = ($urandom_range(99) < rdy_pct);
    bus.out_ready = ($urandom_range(99) < ordy_pct);
    rdr = !rst && (force_rdr || ((rdr_pct > 0) && ($urandom_range(99) < rdr_pct)));
    tgt = rpc;
    if (!force_rdr)
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
    bus.redirect    = rdr;
    bus.redirect_pc = tgt;
    if (!rst && (pend.size() > 0) && (pend[0].due <= 32'(cyc))) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = mem_word(pend[0].addr);
    end else begin
      bus.resp_valid = 1'b0;
      bus.resp_data  = $urandom;
    end
    #1;
    if (check_en) compare_outputs();
    else m_rv = 1'b0;
    s_rv = bus.req_valid;
    s_ra = bus.req_addr;
    @(posedge clk);
    if (rst) pend.delete();
    else begin
      if (bus.resp_valid) void'(pend.pop_front());
      if (s_rv && bus.req_ready) begin
        pend.push_back({s_ra, 32'(cyc + $urandom_range(lat_max, lat_min))});
        n_acc++;
      end
    end
    model_step(rst, m_rv && bus.req_ready, bus.resp_valid, bus.out_ready, rdr, tgt);
    cyc++;
    check_en = 1'b1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_data   = '0;
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // Reset and sequential fetch with 1-cycle memory.
    lat_min = 1; lat_max = 1; rdy_pct = 100; ordy_pct = 100; rdr_pct = 0;
    do_reset();
    #2;
    check("rst_req_valid", 32'(bus.req_valid), 32'h0);
    check("rst_req_addr",  bus.req_addr, 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_pc",    bus.out_pc, 32'h0);
    check("rst_busy",      32'(bus.busy), 32'h0);
    for (int k = 0; k < 10; k++) begin
      run_cycle(1'b0, 1'b0, 32'h0);
      #2;
      if (k == 1) begin
        check("seq_first_valid", 32'(bus.out_valid), 32'h1);
        check("seq_pc0",    bus.out_pc, 32'h0);
        check("seq_instr0", bus.out_instr, 32'hA5A5_0F0F);
      end
      if (k == 2) check("seq_pc4", bus.out_pc, 32'h4);
      if (k == 3) check("seq_pc8", bus.out_pc, 32'h8);
      if (k == 4) check("seq_req_addr5", bus.req_addr, 32'h14);
    end

    // Decode stalled: credit limit caps accepted requests at DEPTH.
    ordy_pct = 0;
    do_reset();
    n_acc = 0;
    for (int k = 0; k < 8; k++) run_cycle(1'b0, 1'b0, 32'h0);
    #2;
    check("stall_accepts",   32'(n_acc), 32'd4);
    check("stall_req_valid", 32'(bus.req_valid), 32'h0);
    check("stall_out_valid", 32'(bus.out_valid), 32'h1);
    check("stall_out_pc",    bus.out_pc, 32'h0);
    ordy_pct = 100;
    for (int k = 0; k < 8; k++) run_cycle(1'b0, 1'b0, 32'h0);

    // L=3, redirect to 0x100 with two requests in flight.
    lat_min = 3; lat_max = 3;
    do_reset();
    run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b1, 32'h100);
    begin
      bit found = 1'b0;
      for (int k = 0; k < 15 && !found; k++) begin
        run_cycle(1'b0, 1'b0, 32'h0);
        #2;
        if (bus.out_valid) begin
          found = 1'b1;
          check("rdr100_first_pc", bus.out_pc, 32'h100);
        end
      end
      check("rdr100_seen", 32'(found), 32'h1);
    end

    // Redirect to 0x203 with a same-cycle response and accept, L=1.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int k = 0; k < 5; k++) run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b1, 32'h203);
    #2;
    check("rdr203_req_addr",  bus.req_addr, 32'h200);
    check("rdr203_out_valid", 32'(bus.out_valid), 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0);
    #2;
    check("rdr203_valid", 32'(bus.out_valid), 32'h1);
    check("rdr203_pc0",   bus.out_pc, 32'h200);
    run_cycle(1'b0, 1'b0, 32'h0);
    #2;
    check("rdr203_pc1",   bus.out_pc, 32'h204);

    // PC wrap at the top of the address space.
    do_reset();
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    #2;
    check("wrap_addr_f8", bus.req_addr, 32'hFFFF_FFF8);
    run_cycle(1'b0, 1'b0, 32'h0);
    #2;
    check("wrap_addr_fc", bus.req_addr, 32'hFFFF_FFFC);
    run_cycle(1'b0, 1'b0, 32'h0);
    #2;
    check("wrap_addr_0",  bus.req_addr, 32'h0);
    check("wrap_req_valid", 32'(bus.req_valid), 32'h1);
    for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b0, 32'h0);

    // Reset with a loaded queue and requests in flight.
    lat_min = 3; lat_max = 3; ordy_pct = 0;
    do_reset();
    for (int k = 0; k < 6; k++) run_cycle(1'b0, 1'b0, 32'h0);
    #2;
    check("pre_rst_busy", 32'(bus.busy), 32'h1);
    run_cycle(1'b1, 1'b0, 32'h0);
    #2;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_busy",      32'(bus.busy), 32'h0);
    check("mid_rst_req_addr",  bus.req_addr, RESET_PC);
    check("mid_rst_req_valid", 32'(bus.req_valid), 32'h0);

    // Randomised traffic: variable latency, backpressure, random redirects.
    lat_min = 1; lat_max = 5; rdy_pct = 70; ordy_pct = 70; rdr_pct = 3;
    do_reset();
    for (int k = 0; k < 3000; k++) run_cycle(1'b0, 1'b0, 32'h0);
    lat_min = 1; lat_max = 1; rdy_pct = 100; ordy_pct = 100; rdr_pct = 2;
    for (int k = 0; k < 1000; k++) run_cycle(1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
